// File: rtl/userio_joy_scan.sv
// userio_joy_scan
// Scan controller for the shared USER joystick port. Time-multiplexes the
// port between a DB15 serial shift-register adapter and a pair of Mega Drive
// 6-button pads on a DB9 splitter. Both 16-bit joystick words update together
// once per scan frame.
//
// Build option: define USERJOY_DB15_EN to compile in the DB15 shift path.
// Without it, mode 2'b01 behaves as off, joy_clk_o/joy_load_o sit at 1 and
// joy_data is ignored.
//
// Ports
//   clk          scan clock (CLK_JOY, 40-50 MHz)
//   reset_n      asynchronous active-low reset
//   mode         [1] DB9MD (wins when both set), [0] DB15, 2'b00 off
//   joy_in       DB9 lines, active-low: pin1,pin2,pin3,pin4,pin6,pin9
//   joy_data     DB15 serial data, active-low
//   joy_clk_o    DB15 shift clock
//   joy_load_o   DB15 parallel load, active-low
//   joy_split_o  DB9 splitter player select (0 = P1)
//   joy_mdsel_o  Mega Drive SELECT line
//   joystick1/2  active-high button words
//   frame_done   one-cycle pulse when joystick1/2 update
//
// State       | meaning
// ------------+----------------------------------------------------
// IDLE        | waiting for frame counter wrap, pins at idle levels
// DB15_LOAD   | load_o low for one tick
// DB15_LO     | shift clock low for one tick
// DB15_HI     | shift clock high for one tick, bit taken on rise
// MD_SPLIT    | splitter switched to current player, settle tick
// MD_PHASE    | one of eight SELECT phases for current player
// UPDATE      | shadow words copied to outputs, frame_done pulse

module userio_joy_scan #(
    parameter int CLK_DIV     = 500,
    parameter int FRAME_TICKS = 1667
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  mode,
    input  logic [5:0]  joy_in,
    input  logic        joy_data,
    output logic        joy_clk_o,
    output logic        joy_load_o,
    output logic        joy_split_o,
    output logic        joy_mdsel_o,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW = $clog2(FRAME_TICKS);

`ifdef USERJOY_DB15_EN
    typedef enum logic [2:0] {
        S_IDLE, S_DB15_LOAD, S_DB15_LO, S_DB15_HI, S_MD_SPLIT, S_MD_PHASE, S_UPDATE
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_MD_SPLIT, S_MD_PHASE, S_UPDATE
    } state_t;
`endif

    state_t         state;
    logic [PW-1:0]  pre_cnt;
    logic [FW-1:0]  frm_cnt;
    logic           tick;
    logic           frame_wrap;
    logic [1:0]     mode_r;
    logic           md_mode;
    logic           player;
    logic [2:0]     phase;
    logic           six;
    logic [11:0]    md_word;
    logic [15:0]    sh1;
    logic [15:0]    sh2;

    assign tick       = (pre_cnt == PW'(CLK_DIV - 1));
    assign frame_wrap = tick && (frm_cnt == FW'(FRAME_TICKS - 1));
    assign md_mode    = mode_r[1];

`ifdef USERJOY_DB15_EN
    logic [5:0] bit_cnt;
    logic       db15_mode;
    assign db15_mode = (mode_r == 2'b01);
`else
    logic unused_joy_data;
    assign unused_joy_data = joy_data;
    assign joy_clk_o  = 1'b1;
    assign joy_load_o = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            frm_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            frm_cnt <= frame_wrap ? '0 : frm_cnt + FW'(1);
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            mode_r      <= 2'b00;
            player      <= 1'b0;
            phase       <= 3'd0;
            six         <= 1'b0;
            md_word     <= '0;
            sh1         <= '0;
            sh2         <= '0;
            joy_split_o <= 1'b0;
            joy_mdsel_o <= 1'b1;
            joystick1   <= '0;
            joystick2   <= '0;
            frame_done  <= 1'b0;
`ifdef USERJOY_DB15_EN
            bit_cnt     <= '0;
            joy_clk_o   <= 1'b1;
            joy_load_o  <= 1'b1;
`endif
        end else begin
            mode_r     <= mode;
            frame_done <= 1'b0;
            if (mode != mode_r) begin
                // Any mode change abandons the frame and blanks the words.
                state       <= S_IDLE;
                joy_split_o <= 1'b0;
                joy_mdsel_o <= 1'b1;
                joystick1   <= '0;
                joystick2   <= '0;
`ifdef USERJOY_DB15_EN
                joy_clk_o   <= 1'b1;
                joy_load_o  <= 1'b1;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (frame_wrap) begin
                            sh1    <= '0;
                            sh2    <= '0;
                            player <= 1'b0;
                            if (md_mode) begin
                                state       <= S_MD_SPLIT;
                                joy_split_o <= 1'b0;
                                joy_mdsel_o <= 1'b1;
                            end
`ifdef USERJOY_DB15_EN
                            else if (db15_mode) begin
                                state      <= S_DB15_LOAD;
                                joy_load_o <= 1'b0;
                                bit_cnt    <= '0;
                            end
`endif
                        end
                    end
`ifdef USERJOY_DB15_EN
                    S_DB15_LOAD: begin
                        if (tick) begin
                            joy_load_o <= 1'b1;
                            joy_clk_o  <= 1'b0;
                            state      <= S_DB15_LO;
                        end
                    end
                    S_DB15_LO: begin
                        if (tick) begin
                            joy_clk_o <= 1'b1;
                            state     <= S_DB15_HI;
                            if (bit_cnt[4])
                                sh2[bit_cnt[3:0]] <= ~joy_data;
                            else
                                sh1[bit_cnt[3:0]] <= ~joy_data;
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    S_DB15_HI: begin
                        if (tick) begin
                            if (bit_cnt == 6'd32) begin
                                state <= S_UPDATE;
                            end else begin
                                joy_clk_o <= 1'b0;
                                state     <= S_DB15_LO;
                            end
                        end
                    end
`endif
                    S_MD_SPLIT: begin
                        if (tick) begin
                            state       <= S_MD_PHASE;
                            phase       <= 3'd0;
                            joy_mdsel_o <= 1'b1;
                            md_word     <= '0;
                            six         <= 1'b0;
                        end
                    end
                    S_MD_PHASE: begin
                        if (tick) begin
                            case (phase)
                                3'd0: begin
                                    md_word[3] <= ~joy_in[0];
                                    md_word[2] <= ~joy_in[1];
                                    md_word[1] <= ~joy_in[2];
                                    md_word[0] <= ~joy_in[3];
                                    md_word[5] <= ~joy_in[4];
                                    md_word[6] <= ~joy_in[5];
                                end
                                3'd1: begin
                                    md_word[4]  <= ~joy_in[4];
                                    md_word[10] <= ~joy_in[5];
                                end
                                3'd5: six <= ~joy_in[0] & ~joy_in[1];
                                3'd6: begin
                                    // Three-button pads repeat the D-pad here;
                                    // only trust it when the pad identified itself.
                                    md_word[9]  <= six & ~joy_in[0];
                                    md_word[8]  <= six & ~joy_in[1];
                                    md_word[7]  <= six & ~joy_in[2];
                                    md_word[11] <= six & ~joy_in[3];
                                end
                                default: ;
                            endcase
                            phase       <= phase + 3'd1;
                            // Next phase is even (SELECT high) when this one is odd.
                            joy_mdsel_o <= phase[0];
                            if (phase == 3'd7) begin
                                if (!player) begin
                                    sh1         <= {4'b0000, md_word};
                                    player      <= 1'b1;
                                    joy_split_o <= 1'b1;
                                    state       <= S_MD_SPLIT;
                                end else begin
                                    sh2   <= {4'b0000, md_word};
                                    state <= S_UPDATE;
                                end
                            end
                        end
                    end
                    S_UPDATE: begin
                        joystick1   <= sh1;
                        joystick2   <= sh2;
                        frame_done  <= 1'b1;
                        joy_split_o <= 1'b0;
                        joy_mdsel_o <= 1'b1;
                        state       <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_userio_joy_scan.sv
module tb_userio_joy_scan;

    localparam int CLK_DIV     = 4;
    localparam int FRAME_TICKS = 100;

    logic        clk;
    logic        reset_n;
    logic [1:0]  mode;
    logic [5:0]  joy_in;
    logic        joy_data;
    logic        joy_clk_o;
    logic        joy_load_o;
    logic        joy_split_o;
    logic        joy_mdsel_o;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        frame_done;

    userio_joy_scan #(.CLK_DIV(CLK_DIV), .FRAME_TICKS(FRAME_TICKS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mode        (mode),
        .joy_in      (joy_in),
        .joy_data    (joy_data),
        .joy_clk_o   (joy_clk_o),
        .joy_load_o  (joy_load_o),
        .joy_split_o (joy_split_o),
        .joy_mdsel_o (joy_mdsel_o),
        .joystick1   (joystick1),
        .joystick2   (joystick2),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pad model: button word uses the DUT output bit order, pressed = 1.
    logic        six1, six2;
    logic [11:0] btn1, btn2;
    logic [2:0]  sel_cnt;

    function automatic logic [5:0] pad_pins(input logic [11:0] b, input logic six, input logic [2:0] ph);
        logic [5:0] p;
        if (!ph[0]) begin
            if (six && ph == 3'd6) p = {b[6], b[5], b[11], b[7], b[8], b[9]};
            else                   p = {b[6], b[5], b[0], b[1], b[2], b[3]};
        end else begin
            p = {b[10], b[4], 1'b1, 1'b1, b[2], b[3]};
            if (six && ph == 3'd5) p[3:0] = 4'b1111;
            if (six && ph == 3'd7) p[3:0] = 4'b0000;
        end
        return ~p;
    endfunction

    // SELECT toggles since the player's first phase equal the phase number mod 8.
    always @(posedge joy_mdsel_o or negedge joy_mdsel_o or negedge reset_n) begin
        if (!reset_n) sel_cnt = 3'd0;
        else          sel_cnt = sel_cnt + 3'd1;
    end

    always @* begin
        joy_in = joy_split_o ? pad_pins(btn2, six2, sel_cnt) : pad_pins(btn1, six1, sel_cnt);
    end

    // DB15 adapter model: bit 0 first after load, advancing on each shift clock rise.
    logic [31:0] db_stream;
    logic [4:0]  db_idx;
    always @(negedge joy_load_o or posedge joy_clk_o) begin
        if (!joy_load_o) db_idx = 5'd0;
        else             db_idx = db_idx + 5'd1;
    end
    always @* joy_data = ~db_stream[db_idx];

    int split_rise = 0, split_fall = 0, load_low_clks = 0, clk_low_clks = 0, done_cnt = 0;
    always @(posedge joy_split_o) split_rise++;
    always @(negedge joy_split_o) split_fall++;
    always @(negedge clk) begin
        if (!joy_load_o) load_low_clks++;
        if (!joy_clk_o)  clk_low_clks++;
        if (frame_done)  done_cnt++;
    end

    task automatic wait_done(input string tag, input int limit, output int clks);
        logic seen;
        seen = 1'b0;
        clks = 0;
        while (!seen && clks < limit) begin
            @(negedge clk);
            clks++;
            if (frame_done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 16'(seen), 16'd1);
    endtask

    typedef struct {
        logic        s1;
        logic [11:0] b1;
        logic        s2;
        logic [11:0] b2;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int clks, sr0, sf0, d0, l0, c0;
        logic seen;

        vecs[0] = '{1'b1, 12'h218, 1'b1, 12'h400, 16'h0218, 16'h0400};
        vecs[1] = '{1'b0, 12'h08B, 1'b0, 12'h050, 16'h000B, 16'h0050};
        vecs[2] = '{1'b1, 12'hFFF, 1'b1, 12'h000, 16'h0FFF, 16'h0000};
        vecs[3] = '{1'b1, 12'h881, 1'b0, 12'h424, 16'h0881, 16'h0424};

        six1 = vecs[0].s1; btn1 = vecs[0].b1;
        six2 = vecs[0].s2; btn2 = vecs[0].b2;
        db_stream = 32'h0000_A5F0;
`ifdef USERJOY_DB15_EN
        mode = 2'b01;
`else
        mode = 2'b10;
`endif
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_clk_o",   16'(joy_clk_o),   16'd1);
        chk("rst_load_o",  16'(joy_load_o),  16'd1);
        chk("rst_split_o", 16'(joy_split_o), 16'd0);
        chk("rst_mdsel_o", 16'(joy_mdsel_o), 16'd1);
        chk("rst_joy1",    joystick1,        16'h0000);
        chk("rst_joy2",    joystick2,        16'h0000);
        chk("rst_done",    16'(frame_done),  16'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

`ifdef USERJOY_DB15_EN
        l0 = load_low_clks;
        wait_done("db15_a", 1000, clks);
        chk("db15_a_joy1", joystick1, 16'hA5F0);
        chk("db15_a_joy2", joystick2, 16'h0000);
        chk("db15_load_low_clks", 16'(load_low_clks - l0), 16'd4);
        db_stream = 32'h1234_8001;
        wait_done("db15_b", 1000, clks);
        chk("db15_period", 16'(clks), 16'd400);
        chk("db15_b_joy1", joystick1, 16'h8001);
        chk("db15_b_joy2", joystick2, 16'h1234);

        // Abort a DB15 frame mid-shift by switching to DB9MD.
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (!joy_clk_o) seen = 1'b1;
        end
        chk("db15_shift_seen", 16'(seen), 16'd1);
        mode = 2'b10;
        sr0 = split_rise;
        @(posedge clk);
        #1;
        chk("abort_joy1",   joystick1,       16'h0000);
        chk("abort_joy2",   joystick2,       16'h0000);
        chk("abort_clk_o",  16'(joy_clk_o),  16'd1);
        chk("abort_load_o", 16'(joy_load_o), 16'd1);
        wait_done("abort_next", 1000, clks);
        chk("abort_next_joy1", joystick1, vecs[0].e1);
        chk("abort_next_joy2", joystick2, vecs[0].e2);
        chk("abort_next_split_rise", 16'(split_rise - sr0), 16'd1);
`else
        wait_done("md_v0", 1000, clks);
        chk("md_v0_joy1", joystick1, vecs[0].e1);
        chk("md_v0_joy2", joystick2, vecs[0].e2);
`endif
        @(negedge clk);
        chk("done_pulse_width", 16'(frame_done), 16'd0);

        for (int v = 1; v < 4; v++) begin
            six1 = vecs[v].s1; btn1 = vecs[v].b1;
            six2 = vecs[v].s2; btn2 = vecs[v].b2;
            sr0 = split_rise;
            sf0 = split_fall;
            wait_done($sformatf("md_v%0d", v), 1000, clks);
            chk($sformatf("md_v%0d_period", v), 16'(clks + 1), 16'd400);
            chk($sformatf("md_v%0d_joy1", v), joystick1, vecs[v].e1);
            chk($sformatf("md_v%0d_joy2", v), joystick2, vecs[v].e2);
            chk($sformatf("md_v%0d_split_rise", v), 16'(split_rise - sr0), 16'd1);
            chk($sformatf("md_v%0d_split_fall", v), 16'(split_fall - sf0), 16'd1);
            chk($sformatf("md_v%0d_split_idle", v), 16'(joy_split_o), 16'd0);
            chk($sformatf("md_v%0d_mdsel_idle", v), 16'(joy_mdsel_o), 16'd1);
            @(negedge clk);
        end

        // Reset while the pad is being stepped through its phases.
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (!joy_mdsel_o) seen = 1'b1;
        end
        chk("md_phase_seen", 16'(seen), 16'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_joy1",    joystick1,        16'h0000);
        chk("midrst_joy2",    joystick2,        16'h0000);
        chk("midrst_mdsel_o", 16'(joy_mdsel_o), 16'd1);
        chk("midrst_split_o", 16'(joy_split_o), 16'd0);
        chk("midrst_clk_o",   16'(joy_clk_o),   16'd1);
        chk("midrst_load_o",  16'(joy_load_o),  16'd1);
        @(negedge clk);
        reset_n = 1'b1;
        wait_done("post_rst", 1000, clks);
        chk("post_rst_latency", 16'(clks), 16'd473);
        chk("post_rst_joy1", joystick1, vecs[3].e1);
        chk("post_rst_joy2", joystick2, vecs[3].e2);

        // Switching off clears the words immediately and stops scanning.
        @(negedge clk);
        mode = 2'b00;
        @(posedge clk);
        #1;
        chk("off_joy1", joystick1, 16'h0000);
        chk("off_joy2", joystick2, 16'h0000);
        d0 = done_cnt;
        repeat (900) @(negedge clk);
        chk("off_no_done", 16'(done_cnt - d0), 16'd0);
        chk("off_joy1_hold", joystick1, 16'h0000);

`ifndef USERJOY_DB15_EN
        mode = 2'b01;
        d0 = done_cnt;
        l0 = load_low_clks;
        c0 = clk_low_clks;
        repeat (900) @(negedge clk);
        chk("nodb15_no_done",   16'(done_cnt - d0),      16'd0);
        chk("nodb15_load_high", 16'(load_low_clks - l0), 16'd0);
        chk("nodb15_clk_high",  16'(clk_low_clks - c0),  16'd0);
        chk("nodb15_joy1",      joystick1,               16'h0000);
        chk("nodb15_joy2",      joystick2,               16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
